// File: rtl/prog_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_arbiter
// Purpose  : Arbitrates a CPU instruction-fetch port and a program-loader
//            write port onto a single program memory. One transaction is in
//            flight at a time (IDLE -> ACCESS -> DONE, or IDLE -> DONE when
//            the address is rejected). Addresses are checked against an
//            inclusive, word-aligned window and translated to window offsets.
//            When both ports request, the loader wins unless it has already
//            won MAX_STREAK grants in a row against a waiting fetch.
// Ports    : CLK, RST (async, active-high)
//            fetch_req/fetch_addr -> fetch_ack/fetch_data/fetch_err
//            load_req/load_addr/load_data -> load_ack/load_err
//            mem_cs/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//            busy (FSM not idle), err_count (saturating error counter)
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h18C0,
  parameter logic [31:0] LIMIT_ADDR  = 32'h1CBF,
  parameter int          MEM_LATENCY = 1,
  parameter int          MAX_STREAK  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  output logic [31:0] fetch_data,
  output logic        fetch_err,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ack,
  output logic        load_err,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Cycles remaining in ACCESS are counted down to zero; a read starts at
  // MEM_LATENCY-1 so it spends exactly MEM_LATENCY cycles with mem_cs high.
  localparam logic [1:0] C_LAT_LAST   = 2'(MEM_LATENCY - 1);
  localparam logic [2:0] C_MAX_STREAK = 3'(MAX_STREAK);

  state_t      r_state;
  logic        r_is_fetch;
  logic [1:0]  r_lat_cnt;
  logic [2:0]  r_streak;

  logic        w_pick_fetch;
  logic [31:0] w_addr;
  logic        w_addr_ok;

  always_comb begin
    // Fetch is served when it is alone, or when the loader has used up its
    // allowance of consecutive wins while the fetch was waiting.
    w_pick_fetch = fetch_req && (!load_req || (r_streak == C_MAX_STREAK));
    w_addr       = w_pick_fetch ? fetch_addr : load_addr;
    w_addr_ok    = (w_addr >= BASE_ADDR) && (w_addr <= LIMIT_ADDR) &&
                   (w_addr[1:0] == 2'b00);
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_is_fetch <= 1'b0;
      r_lat_cnt  <= 2'd0;
      r_streak   <= 3'd0;
      err_count  <= 8'd0;
      fetch_ack  <= 1'b0;
      fetch_err  <= 1'b0;
      fetch_data <= 32'd0;
      load_ack   <= 1'b0;
      load_err   <= 1'b0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      // Acks and error flags are single-cycle pulses raised only on entry
      // to DONE.
      fetch_ack <= 1'b0;
      fetch_err <= 1'b0;
      load_ack  <= 1'b0;
      load_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (fetch_req || load_req) begin
            r_is_fetch <= w_pick_fetch;
            if (w_pick_fetch) begin
              r_streak <= 3'd0;
            end else if (fetch_req && (r_streak != C_MAX_STREAK)) begin
              r_streak <= r_streak + 3'd1;
            end

            if (w_addr_ok) begin
              r_state   <= S_ACCESS;
              mem_cs    <= 1'b1;
              mem_we    <= !w_pick_fetch;
              mem_addr  <= w_addr - BASE_ADDR;
              mem_wdata <= w_pick_fetch ? 32'd0 : load_data;
              r_lat_cnt <= w_pick_fetch ? C_LAT_LAST : 2'd0;
            end else begin
              // Rejected address: skip the memory entirely.
              r_state   <= S_DONE;
              fetch_ack <= w_pick_fetch;
              fetch_err <= w_pick_fetch;
              load_ack  <= !w_pick_fetch;
              load_err  <= !w_pick_fetch;
              if (w_pick_fetch) begin
                fetch_data <= 32'd0;
              end
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
            end
          end
        end

        S_ACCESS: begin
          if (r_lat_cnt == 2'd0) begin
            r_state   <= S_DONE;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if (r_is_fetch) begin
              fetch_ack  <= 1'b1;
              fetch_data <= mem_rdata;
            end else begin
              load_ack <= 1'b1;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end

        // No grant here: a still-held request is taken on the next IDLE edge.
        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem_arbiter
// Purpose  : Self-checking bench for prog_mem_arbiter. A directed table of
//            single-requester transactions, hand-written arbitration, reset
//            and abandoned-request sequences, a randomized two-requester
//            phase scored against a transaction-level model, and an error
//            counter saturation run. Program memory is modelled as a
//            256-word array that the DUT writes and reads.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_mem_arbiter;

  localparam logic [31:0] C_BASE   = 32'h18C0;
  localparam logic [31:0] C_LIMIT  = 32'h1CBF;
  localparam int          C_LAT    = 1;
  localparam int          C_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        load_req = 1'b0;
  logic [31:0] load_addr = 32'd0;
  logic [31:0] load_data = 32'd0;
  logic        load_ack;
  logic        load_err;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [7:0]  err_count;

  prog_mem_arbiter #(
    .BASE_ADDR  (C_BASE),
    .LIMIT_ADDR (C_LIMIT),
    .MEM_LATENCY(C_LAT),
    .MAX_STREAK (C_STREAK)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .fetch_req (fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ack (fetch_ack),
    .fetch_data(fetch_data),
    .fetch_err (fetch_err),
    .load_req  (load_req),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_ack  (load_ack),
    .load_err  (load_err),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // ---------------- program memory model ----------------
  function automatic logic [31:0] init_word(input logic [7:0] idx);
    return {idx, 8'h5A, ~idx, 8'hC3};
  endfunction

  bit   [31:0] pm   [256];
  bit          pm_v [256];
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed    = 32'd0;

  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      pm[mem_addr[9:2]]   <= mem_wdata;
      pm_v[mem_addr[9:2]] <= 1'b1;
    end
  end

  assign mem_rdata = rd_fixed_en ? rd_fixed :
                     (pm_v[mem_addr[9:2]] ? pm[mem_addr[9:2]] : init_word(mem_addr[9:2]));

  // ---------------- scoring ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no ack within cycle budget (t=%0t)", name, $time);
  endtask

  // Waits for one ack; edges are counted from the first edge after the call.
  task automatic serve(output bit gf, output bit gl, output int edges, output int cs_cnt,
                       output bit swe, output logic [31:0] saddr, output logic [31:0] swd,
                       output bit err, output logic [31:0] data);
    gf = 0; gl = 0; edges = 0; cs_cnt = 0; swe = 0;
    saddr = 32'd0; swd = 32'd0; err = 0; data = 32'd0;
    while (!gf && !gl && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (mem_cs) begin
        cs_cnt++;
        swe   = mem_we;
        saddr = mem_addr;
        swd   = mem_wdata;
      end
      if (fetch_ack) begin gf = 1; err = fetch_err; data = fetch_data; end
      if (load_ack)  begin gl = 1; err = load_err; end
    end
    if (!gf && !gl) fail_now("ack_wait");
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return C_BASE + ($urandom_range(0, 255) << 2);
      3:       return C_BASE + $urandom_range(0, 1023);
      4: case ($urandom_range(0, 3))
           0:       return C_BASE - 32'd4;
           1:       return C_LIMIT + 32'd1;
           2:       return C_LIMIT - 32'd3;
           default: return C_BASE;
         endcase
      default: return $urandom;
    endcase
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= C_BASE) && (a <= C_LIMIT) && ((a % 4) == 0);
  endfunction

  typedef struct {
    bit          is_f;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_cs;
    logic [31:0] exp_maddr;
    logic [31:0] exp_data;
    int          exp_errcnt;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] model_mem [256];

  bit          gf, gl, swe, err;
  int          edges, cs_cnt;
  logic [31:0] saddr, swd, data;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          pend_f, pend_l, win_f, ok, seen;
    logic [31:0] a;
    int          m_streak, m_errcnt, exp_lat;

    for (int i = 0; i < 256; i++) model_mem[i] = init_word(8'(i));

    //            is_f  addr          wdata         rdata         err  lat cs maddr     data          errcnt
    tbl[0] = '{1'b1, 32'h0000_18C0, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 32'h000, 32'hDEADBEEF, 0};
    tbl[1] = '{1'b0, 32'h0000_1CBC, 32'h12345678, 32'h0,        1'b0, 2, 1, 32'h3FC, 32'h12345678, 0};
    tbl[2] = '{1'b1, 32'h0000_1CC0, 32'h0,        32'h11111111, 1'b1, 1, 0, 32'h000, 32'h0,        1};
    tbl[3] = '{1'b1, 32'h0000_18C2, 32'h0,        32'h22222222, 1'b1, 1, 0, 32'h000, 32'h0,        2};
    tbl[4] = '{1'b0, 32'h0000_18BC, 32'h55555555, 32'h0,        1'b1, 1, 0, 32'h000, 32'h0,        3};
    tbl[5] = '{1'b1, 32'h0000_1CBC, 32'h0,        32'hCAFEF00D, 1'b0, 2, 1, 32'h3FC, 32'hCAFEF00D, 3};
    tbl[6] = '{1'b0, 32'h0000_1CBF, 32'h66666666, 32'h0,        1'b1, 1, 0, 32'h000, 32'h0,        4};
    tbl[7] = '{1'b1, 32'hFFFF_FFFC, 32'h0,        32'h33333333, 1'b1, 1, 0, 32'h000, 32'h0,        5};
    tbl[8] = '{1'b0, 32'h0000_18C4, 32'hA5A55A5A, 32'h0,        1'b0, 2, 1, 32'h004, 32'hA5A55A5A, 5};
    tbl[9] = '{1'b1, 32'h0000_0000, 32'h0,        32'h44444444, 1'b1, 1, 0, 32'h000, 32'h0,        6};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy",       busy,       0);
    check("rst_mem_cs",     mem_cs,     0);
    check("rst_acks",       {fetch_ack, load_ack, fetch_err, load_err}, 0);
    check("rst_err_count",  err_count,  0);
    check("rst_fetch_data", fetch_data, 0);
    check("rst_mem_addr",   mem_addr,   0);

    // ---------------- directed table ----------------
    rd_fixed_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_fixed = tbl[i].rdata;
      if (tbl[i].is_f) begin
        fetch_addr = tbl[i].addr; fetch_req = 1'b1;
      end else begin
        load_addr = tbl[i].addr; load_data = tbl[i].wdata; load_req = 1'b1;
      end
      serve(gf, gl, edges, cs_cnt, swe, saddr, swd, err, data);
      fetch_req = 1'b0; load_req = 1'b0;
      check("tbl_who",       {30'd0, gf, gl}, {30'd0, tbl[i].is_f, !tbl[i].is_f});
      check("tbl_err",       err,       tbl[i].exp_err);
      check("tbl_latency",   edges,     tbl[i].exp_lat);
      check("tbl_cs_cycles", cs_cnt,    tbl[i].exp_cs);
      check("tbl_err_count", err_count, tbl[i].exp_errcnt);
      check("tbl_mem_idle",  {mem_cs, mem_we} | mem_addr, 0);
      if (!tbl[i].exp_err) begin
        check("tbl_mem_addr", saddr, tbl[i].exp_maddr);
        check("tbl_mem_we",   swe,   !tbl[i].is_f);
      end
      if (tbl[i].is_f)            check("tbl_fetch_data", data, tbl[i].exp_data);
      else if (!tbl[i].exp_err)   check("tbl_mem_wdata",  swd,  tbl[i].exp_data);
      if (!tbl[i].is_f && !tbl[i].exp_err)
        model_mem[(tbl[i].addr - C_BASE) >> 2] = tbl[i].wdata;
      @(posedge clk); #1;
      check("tbl_back_idle", busy, 0);
    end
    rd_fixed_en = 1'b0;

    // ---------------- arbitration with both held ----------------
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    fetch_addr = 32'h18C0; fetch_req = 1'b1;
    load_addr  = 32'h18C8; load_data = 32'hA000_0000; load_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      serve(gf, gl, edges, cs_cnt, swe, saddr, swd, err, data);
      check("arb_order", {30'd0, gf, gl}, (i % 5 == 4) ? 32'd2 : 32'd1);
      if (gl) model_mem[2] = load_data;
      load_data = 32'hA000_0001 + i;
    end
    fetch_req = 1'b0; load_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // ---------------- request dropped after grant ----------------
    load_addr = 32'h18D0; load_data = 32'h0BADF00D; load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
    serve(gf, gl, edges, cs_cnt, swe, saddr, swd, err, data);
    check("abandon_load_ack", {gf, gl, err}, 3'b010);
    model_mem[4] = 32'h0BADF00D;
    @(posedge clk); #1;

    // ---------------- reset during read access ----------------
    fetch_addr = 32'h18C0; fetch_req = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_cs_before", mem_cs, 1);
    rst = 1'b1; #1;
    check("rst_mid_async", {mem_cs, busy, fetch_ack}, 0);
    @(posedge clk); #1 fetch_req = 1'b0; rst = 1'b0;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; seen |= fetch_ack | mem_cs; end
    check("rst_mid_no_ack", seen, 0);
    check("rst_mid_err_count", err_count, 0);
    check("rst_mid_fetch_data", fetch_data, 0);

    // ---------------- randomized two-requester traffic ----------------
    m_streak = 0; m_errcnt = 0; pend_f = 0; pend_l = 0;
    for (int s = 0; s < 300; s++) begin
      if (!pend_f && $urandom_range(0, 9) < 7) begin
        pend_f = 1; fetch_addr = rand_addr(); fetch_req = 1'b1;
      end
      if (!pend_l && $urandom_range(0, 9) < 7) begin
        pend_l = 1; load_addr = rand_addr(); load_data = $urandom; load_req = 1'b1;
      end
      if (!pend_f && !pend_l) begin
        pend_f = 1; fetch_addr = rand_addr(); fetch_req = 1'b1;
      end
      win_f = pend_f && (!pend_l || m_streak == C_STREAK);
      if (win_f)                              m_streak = 0;
      else if (pend_f && m_streak < C_STREAK) m_streak++;
      a  = win_f ? fetch_addr : load_addr;
      ok = addr_ok(a);
      if (!ok && m_errcnt < 255) m_errcnt++;
      exp_lat = !ok ? 1 : (win_f ? C_LAT + 1 : 2);

      serve(gf, gl, edges, cs_cnt, swe, saddr, swd, err, data);
      check("rnd_who",       {30'd0, gf, gl}, {30'd0, win_f, !win_f});
      check("rnd_err",       err,       !ok);
      check("rnd_latency",   edges,     exp_lat);
      check("rnd_err_count", err_count, m_errcnt);
      if (ok) begin
        check("rnd_cs_cycles", cs_cnt, win_f ? C_LAT : 1);
        check("rnd_mem_addr",  saddr,  a - C_BASE);
        check("rnd_mem_we",    swe,    !win_f);
      end else begin
        check("rnd_err_no_cs", cs_cnt, 0);
      end
      if (win_f) begin
        check("rnd_fetch_data", data, ok ? model_mem[(a - C_BASE) >> 2] : 32'd0);
        fetch_req = 1'b0; pend_f = 0;
      end else begin
        if (ok) begin
          check("rnd_mem_wdata", swd, load_data);
          model_mem[(a - C_BASE) >> 2] = load_data;
        end
        load_req = 1'b0; pend_l = 0;
      end
      @(posedge clk); #1;
    end
    fetch_req = 1'b0; load_req = 1'b0;
    @(posedge clk); #1;

    // ---------------- error counter saturation ----------------
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    load_addr = 32'h0000_0000; load_req = 1'b1;
    for (int i = 0; i < 260; i++) begin
      serve(gf, gl, edges, cs_cnt, swe, saddr, swd, err, data);
      if (i == 254) check("sat_at_255", err_count, 8'd255);
    end
    load_req = 1'b0;
    check("sat_err_count", err_count, 8'd255);
    check("sat_last_err",  {gl, err}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
